// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter that lets several requesters burst words into the
//   write side of a single FIFO. One requester owns the FIFO at a time for up
//   to max_burst accepted beats. A beat is accepted only while the FIFO keeps
//   full_margin free slots, because fifo_wrusedw lags the registered write.
//
// Ports
//   clock         : the only clock, rising edge
//   sclr          : synchronous active-high clear
//   req           : per-requester word valid
//   req_data      : requester i drives bits [i*lpm_width +: lpm_width]
//   req_last      : per-requester last word of its burst
//   ack           : per-requester word accepted this cycle (combinational)
//   fifo_wrusedw  : FIFO write-side used-words count
//   fifo_wrfull   : FIFO write-side full flag
//   fifo_wrreq    : registered FIFO write request
//   fifo_data     : registered FIFO write data
//   grant_id      : index of the current owner, meaningful while busy
//   busy          : a burst is in progress
//   overflow_err  : sticky, a write was issued while the FIFO reported full
//
// FSM states
//   state    | meaning
//   ST_IDLE  | no owner; round-robin pick from rr_ptr, grant on next edge
//   ST_BURST | grant_id owns the FIFO; beats accepted while space_ok

module fifo_wr_arbiter #(
  parameter int num_requesters = 4,
  parameter int lpm_width      = 32,
  parameter int lpm_widthu     = 5,
  parameter int lpm_numwords   = 32,
  parameter int max_burst      = 4,
  parameter int full_margin    = 2
) (
  input  logic                                clock,
  input  logic                                sclr,
  input  logic [num_requesters-1:0]           req,
  input  logic [num_requesters*lpm_width-1:0] req_data,
  input  logic [num_requesters-1:0]           req_last,
  output logic [num_requesters-1:0]           ack,
  input  logic [lpm_widthu-1:0]               fifo_wrusedw,
  input  logic                                fifo_wrfull,
  output logic                                fifo_wrreq,
  output logic [lpm_width-1:0]                fifo_data,
  output logic [2:0]                          grant_id,
  output logic                                busy,
  output logic                                overflow_err
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Compared one bit wider than the used-words count so a depth equal to
  // 2**lpm_widthu still yields a correct threshold.
  localparam logic [lpm_widthu:0] space_lim = (lpm_widthu+1)'(lpm_numwords - full_margin);
  localparam logic [3:0]          last_beat = 4'(max_burst - 1);

  state_t               state_q, state_d;
  logic [2:0]           rr_ptr_q, rr_ptr_d;
  logic [2:0]           grant_id_q, grant_id_d;
  logic [3:0]           beat_cnt_q, beat_cnt_d;
  logic                 fifo_wrreq_q, fifo_wrreq_d;
  logic [lpm_width-1:0] fifo_data_q, fifo_data_d;
  logic                 overflow_q, overflow_d;

  logic                 space_ok;
  logic                 own_req;
  logic                 own_last;
  logic [lpm_width-1:0] own_data;
  logic                 pick_valid;
  logic [2:0]           pick_id;
  logic [2:0]           grant_nxt;
  logic [3:0]           idx_w;

  assign space_ok = !fifo_wrfull && ({1'b0, fifo_wrusedw} < space_lim);

  assign grant_nxt = (grant_id_q == 3'(num_requesters - 1)) ? 3'd0 : grant_id_q + 3'd1;

  // Signals of the current owner, muxed by grant_id_q.
  always_comb begin
    own_req  = 1'b0;
    own_last = 1'b0;
    own_data = '0;
    for (int i = 0; i < num_requesters; i++) begin
      if (grant_id_q == 3'(i)) begin
        own_req  = req[i];
        own_last = req_last[i];
        own_data = req_data[i*lpm_width +: lpm_width];
      end
    end
  end

  // Round-robin search starting at rr_ptr_q. Offsets are walked from the
  // farthest to the nearest so the nearest requesting index wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    idx_w      = '0;
    for (int k = num_requesters - 1; k >= 0; k--) begin
      idx_w = {1'b0, rr_ptr_q} + 4'(k);
      if (idx_w >= 4'(num_requesters)) begin
        idx_w = idx_w - 4'(num_requesters);
      end
      for (int j = 0; j < num_requesters; j++) begin
        if (idx_w == 4'(j) && req[j]) begin
          pick_valid = 1'b1;
          pick_id    = 3'(j);
        end
      end
    end
  end

  always_comb begin
    ack = '0;
    if (state_q == ST_BURST) begin
      for (int i = 0; i < num_requesters; i++) begin
        if (grant_id_q == 3'(i)) begin
          ack[i] = own_req && space_ok;
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_id_d   = grant_id_q;
    beat_cnt_d   = beat_cnt_q;
    fifo_wrreq_d = 1'b0;
    fifo_data_d  = fifo_data_q;
    overflow_d   = overflow_q | (fifo_wrreq_q & fifo_wrfull);

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_id_d = pick_id;
          beat_cnt_d = '0;
          state_d    = ST_BURST;
        end
      end
      ST_BURST: begin
        if (!own_req) begin
          // Owner withdrew: give up the grant without accepting anything.
          state_d  = ST_IDLE;
          rr_ptr_d = grant_nxt;
        end else if (space_ok) begin
          fifo_wrreq_d = 1'b1;
          fifo_data_d  = own_data;
          beat_cnt_d   = beat_cnt_q + 4'd1;
          if (own_last || beat_cnt_q == last_beat) begin
            state_d  = ST_IDLE;
            rr_ptr_d = grant_nxt;
          end
        end
        // Otherwise stall: hold the grant, beat count untouched.
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (sclr) begin
      state_q      <= ST_IDLE;
      rr_ptr_q     <= '0;
      grant_id_q   <= '0;
      beat_cnt_q   <= '0;
      fifo_wrreq_q <= 1'b0;
      fifo_data_q  <= '0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_id_q   <= grant_id_d;
      beat_cnt_q   <= beat_cnt_d;
      fifo_wrreq_q <= fifo_wrreq_d;
      fifo_data_q  <= fifo_data_d;
      overflow_q   <= overflow_d;
    end
  end

  assign fifo_wrreq   = fifo_wrreq_q;
  assign fifo_data    = fifo_data_q;
  assign grant_id     = grant_id_q;
  assign busy         = (state_q == ST_BURST);
  assign overflow_err = overflow_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter. Requester models offer numbered words
// and advance on ack; each scenario pushes its hand-ordered list of expected
// FIFO words, and a monitor pops one entry per observed fifo_wrreq.

module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int W  = 32;
  localparam int WU = 5;

  logic            clock = 1'b0;
  logic            sclr;
  logic [NR-1:0]   req;
  logic [NR*W-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   ack;
  logic [WU-1:0]   fifo_wrusedw;
  logic            fifo_wrfull;
  logic            fifo_wrreq;
  logic [W-1:0]    fifo_data;
  logic [2:0]      grant_id;
  logic            busy;
  logic            overflow_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  int wcnt[NR];
  int total[NR];
  int last_at[NR];
  int scen;
  int usedw_v;
  logic wrfull_v;
  logic sclr_v;
  logic [NR-1:0] last_ack;

  logic [W-1:0] exp_q[$];
  int           wr_cyc[$];

  fifo_wr_arbiter dut (
    .clock        (clock),
    .sclr         (sclr),
    .req          (req),
    .req_data     (req_data),
    .req_last     (req_last),
    .ack          (ack),
    .fifo_wrusedw (fifo_wrusedw),
    .fifo_wrfull  (fifo_wrfull),
    .fifo_wrreq   (fifo_wrreq),
    .fifo_data    (fifo_data),
    .grant_id     (grant_id),
    .busy         (busy),
    .overflow_err (overflow_err)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [W-1:0] word(int s, int i, int n);
    return {8'(8'hA0 + s), 8'(i), 16'(n)};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clock) begin
    if (fifo_wrreq === 1'b1) begin
      wr_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got data %0h, expected no write (cycle %0d)", fifo_data, cyc);
      end else begin
        check("write_data", fifo_data, exp_q.pop_front());
      end
    end
  end

  task automatic drive_inputs();
    for (int i = 0; i < NR; i++) begin
      req[i]              = (wcnt[i] < total[i]);
      req_last[i]         = (wcnt[i] == last_at[i]);
      req_data[i*W +: W]  = word(scen, i, wcnt[i]);
    end
    fifo_wrusedw = WU'(usedw_v);
    fifo_wrfull  = wrfull_v;
    sclr         = sclr_v;
  endtask

  task automatic step();
    @(negedge clock);
    drive_inputs();
    #1;
    last_ack = ack;
    for (int i = 0; i < NR; i++) begin
      if (ack[i]) wcnt[i]++;
    end
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < NR; i++) begin
      wcnt[i]    = 0;
      total[i]   = 0;
      last_at[i] = -1;
    end
  endtask

  task automatic do_reset();
    sclr_v = 1'b1;
    step();
    step();
    sclr_v = 1'b0;
    clear_reqs();
    exp_q.delete();
    wr_cyc.delete();
  endtask

  task automatic run_until_empty(string name, int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic idle_steps(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int n;
    scen     = 0;
    usedw_v  = 0;
    wrfull_v = 1'b0;
    sclr_v   = 1'b1;
    clear_reqs();
    drive_inputs();

    // Reset state
    do_reset();
    check("rst_busy", busy, 0);
    check("rst_wrreq", fifo_wrreq, 0);
    check("rst_data", fifo_data, 0);
    check("rst_overflow", overflow_err, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_ack", ack, 0);

    // Requesters 0 and 2, four words each, no last
    scen = 1;
    total[0] = 4;
    total[2] = 4;
    for (int b = 0; b < 4; b++) exp_q.push_back(word(1, 0, b));
    for (int b = 0; b < 4; b++) exp_q.push_back(word(1, 2, b));
    wr_cyc.delete();
    run_until_empty("s1_done", 40);
    check("s1_nwrites", wr_cyc.size(), 8);
    if (wr_cyc.size() == 8) begin
      for (int k = 0; k < 7; k++) check("s1_gap", wr_cyc[k+1] - wr_cyc[k], (k == 3) ? 2 : 1);
    end
    idle_steps(3);
    check("s1_busy_end", busy, 0);

    // Requester 1 alone with last on its second word
    clear_reqs();
    scen = 2;
    total[1]   = 2;
    last_at[1] = 1;
    exp_q.push_back(word(2, 1, 0));
    exp_q.push_back(word(2, 1, 1));
    run_until_empty("s2_done", 20);
    check("s2_busy_fall", busy, 0);
    idle_steps(3);

    // rr_ptr now 2: with 0 and 2 requesting, 2 must win first
    clear_reqs();
    scen = 3;
    total[0] = 1;
    total[2] = 1;
    exp_q.push_back(word(3, 2, 0));
    exp_q.push_back(word(3, 0, 0));
    run_until_empty("s2_rr_done", 20);
    idle_steps(3);

    // Stall at used-words 30, resume at 29; stall cycles do not count as beats
    clear_reqs();
    scen = 4;
    total[3] = 6;
    for (int b = 0; b < 6; b++) exp_q.push_back(word(4, 3, b));
    wr_cyc.delete();
    n = 0;
    while (wcnt[3] < 1 && n < 20) begin
      step();
      n++;
    end
    check("s3_first_beat", wcnt[3], 1);
    usedw_v = 30;
    for (int s = 0; s < 5; s++) begin
      step();
      check("s3_stall_ack", last_ack, 0);
      check("s3_stall_busy", busy, 1);
      if (s > 0) check("s3_stall_wrreq", fifo_wrreq, 0);
    end
    usedw_v = 29;
    run_until_empty("s3_done", 40);
    check("s3_nwrites", wr_cyc.size(), 6);
    if (wr_cyc.size() == 6) begin
      check("s3_gap_stall", wr_cyc[1] - wr_cyc[0], 6);
      check("s3_gap_b2", wr_cyc[2] - wr_cyc[1], 1);
      check("s3_gap_b3", wr_cyc[3] - wr_cyc[2], 1);
      check("s3_gap_burst_end", wr_cyc[4] - wr_cyc[3], 2);
      check("s3_gap_b5", wr_cyc[5] - wr_cyc[4], 1);
    end
    usedw_v = 0;
    idle_steps(3);

    // All four requesting: grant order 0,1,2,3,0 with full bursts
    do_reset();
    scen = 5;
    total[0] = 8;
    total[1] = 4;
    total[2] = 4;
    total[3] = 4;
    for (int r = 0; r < 4; r++) begin
      for (int b = 0; b < 4; b++) exp_q.push_back(word(5, r, b));
    end
    for (int b = 4; b < 8; b++) exp_q.push_back(word(5, 0, b));
    run_until_empty("s4_done", 80);
    check("s4_nwrites", wr_cyc.size(), 20);
    if (wr_cyc.size() == 20) begin
      for (int k = 0; k < 19; k++) check("s4_gap", wr_cyc[k+1] - wr_cyc[k], (k % 4 == 3) ? 2 : 1);
    end
    idle_steps(3);

    // sclr on beat 2 of a burst
    clear_reqs();
    scen = 6;
    total[3] = 8;
    exp_q.push_back(word(6, 3, 0));
    exp_q.push_back(word(6, 3, 1));
    n = 0;
    while (wcnt[3] < 2 && n < 20) begin
      step();
      n++;
    end
    check("s5_two_beats", wcnt[3], 2);
    sclr_v = 1'b1;
    step();
    sclr_v = 1'b0;
    clear_reqs();
    scen = 7;
    total[0] = 1;
    total[3] = 1;
    exp_q.push_back(word(7, 0, 0));
    exp_q.push_back(word(7, 3, 0));
    step();
    check("s5_no_wrreq_after_sclr", fifo_wrreq, 0);
    check("s5_busy_after_sclr", busy, 0);
    run_until_empty("s5_done", 30);
    idle_steps(3);

    // Overflow: full alone does nothing, full during a write is sticky
    clear_reqs();
    scen = 8;
    wrfull_v = 1'b1;
    idle_steps(2);
    check("s6_no_overflow_idle", overflow_err, 0);
    wrfull_v = 1'b0;
    total[1] = 1;
    exp_q.push_back(word(8, 1, 0));
    n = 0;
    while (wcnt[1] < 1 && n < 20) begin
      step();
      n++;
    end
    wrfull_v = 1'b1;
    step();
    check("s6_wrreq_with_full", fifo_wrreq, 1);
    wrfull_v = 1'b0;
    step();
    check("s6_overflow_set", overflow_err, 1);
    for (int k = 0; k < 3; k++) begin
      step();
      check("s6_overflow_hold", overflow_err, 1);
    end
    check("s6_done", exp_q.size(), 0);
    do_reset();
    check("s6_overflow_cleared", overflow_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog");
  end

endmodule
